// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared mips32 constants: opcodes, instruction types, memory responder FSM and port ids
package mips32_pkg;

    // Core opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    // Instruction classes carried down the core pipeline
    localparam logic [2:0] TYPE_RR_ALU = 3'b000;
    localparam logic [2:0] TYPE_RM_ALU = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_STORE  = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_HALT   = 3'b101;

    // Memory responder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } mem_state_t;

    // Identifies which requester owns the transaction in flight
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Wait-state counter width; WAIT_CYC must fit (0..15)
    localparam int WAIT_CNT_W = 4;

    // Classifies an opcode into the type the core uses to steer its pipeline
    function automatic logic [2:0] instr_type(input logic [5:0] opcode);
        logic [2:0] t;
        t = TYPE_HALT;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = TYPE_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                      t = TYPE_RM_ALU;
            OP_LW:                                          t = TYPE_LOAD;
            OP_SW:                                          t = TYPE_STORE;
            OP_BNEQZ, OP_BEQZ:                              t = TYPE_BRANCH;
            default:                                        t = TYPE_HALT;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_mem_array.sv
// rtl/mips32_mem_array.sv - single-port synchronous word RAM with registered read data
// Ports:
//   clk1   in   1       clock, rising edge
//   en     in   1       access strobe; read data and writes only happen when high
//   we     in   1       write enable (qualified by en)
//   addr   in   ADDR_W  word address
//   wdata  in   32      write data
//   rdata  out  32      registered read data (read-before-write on a store)
module mips32_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk1,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Named Mem so benches can preload contents hierarchically; contents are never reset
    logic [31:0] Mem [0:DEPTH-1];

    always_ff @(posedge clk1) begin
        if (en) begin
            if (we) begin
                Mem[addr] <= wdata;
            end
            rdata <= Mem[addr];
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - shared I/D memory responder with wait states for the mips32 core
// Ports:
//   clk1, rst_n                    clock (rising edge), synchronous active-low reset
//   i_req_valid/ready/addr         instruction fetch request channel
//   i_rsp_valid/ready/data         instruction fetch response channel
//   d_req_valid/ready/we/addr/wdata load/store request channel
//   d_rsp_valid/ready/data         load data / store ack channel
//   busy                           high whenever a transaction is in flight
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [31:0]       d_rsp_data,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYC);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(1);
    localparam logic [ADDR_W:0]       DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    mem_state_t state_q;
    mem_state_t state_d;

    logic [WAIT_CNT_W-1:0] cnt_q;

    // Request latch: captured only on the accepting handshake
    logic              port_q;
    logic              we_q;
    logic              oor_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;

    logic              grant_i;
    logic              grant_d;
    logic              accept;
    logic              rsp_ready_sel;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;

    // ---------------- FSM ----------------
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        mem_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Data port has fixed priority; fetch may starve under continuous D traffic
                if (d_req_valid) begin
                    grant_d = 1'b1;
                end else if (i_req_valid) begin
                    grant_i = 1'b1;
                end
                if (grant_d || grant_i) begin
                    state_d = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= WAIT_LAST) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready_sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are only raised for a valid requester, so grant == handshake
    assign i_req_ready   = grant_i;
    assign d_req_ready   = grant_d;
    assign accept        = grant_i | grant_d;
    assign sel_addr      = grant_d ? d_req_addr : i_req_addr;
    assign sel_oor       = ({1'b0, sel_addr} >= DEPTH_LIM);
    assign rsp_ready_sel = (port_q == PORT_D) ? d_rsp_ready : i_rsp_ready;

    // ACCESS is the single commit point; a reset arriving that same edge abandons the store
    assign mem_we = mem_en & we_q & ~oor_q & rst_n;

    // ---------------- request latch, wait counter, response register ----------------
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            port_q      <= PORT_I;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (accept) begin
                port_q  <= grant_d ? PORT_D : PORT_I;
                we_q    <= grant_d & d_req_we;
                addr_q  <= sel_addr;
                wdata_q <= grant_d ? d_req_wdata : 32'h0;
                oor_q   <= sel_oor;
                cnt_q   <= WAIT_INIT;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - WAIT_LAST;
            end

            // RAM output is registered, so the response word is captured on the
            // first RESP cycle and then held until the handshake
            if (state_q == ST_RESP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    if (we_q) begin
                        rsp_data_q <= wdata_q;
                    end else if (oor_q) begin
                        rsp_data_q <= 32'h0;
                    end else begin
                        rsp_data_q <= mem_rdata;
                    end
                end else if (rsp_ready_sel) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end
    end

    assign i_rsp_valid = rsp_valid_q & (port_q == PORT_I);
    assign d_rsp_valid = rsp_valid_q & (port_q == PORT_D);
    assign i_rsp_data  = rsp_data_q;
    assign d_rsp_data  = rsp_data_q;
    assign busy        = (state_q != ST_IDLE);

    mips32_mem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk1  (clk1),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule
